// File: rtl/gd_grad_if.sv
// Link between the iteration controller and the gradient/value/step unit.
// Handshake: grad_start is a one-cycle request that launches evaluation of grad_x. grad_done is a level
// that the unit may hold across requests. The result fields are valid whenever grad_done is high.
// There is no back-pressure: the controller consumes the result on the cycle it accepts grad_done.
interface gd_grad_if;
  logic        grad_start;
  logic [31:0] grad_x;
  logic        grad_done;
  logic [31:0] grad_x_diff;
  logic [63:0] grad_value;
  logic        grad_overflow;

  modport master (
    output grad_start, grad_x,
    input  grad_done, grad_x_diff, grad_value, grad_overflow
  );

  modport slave (
    input  grad_start, grad_x,
    output grad_done, grad_x_diff, grad_value, grad_overflow
  );
endinterface

// File: rtl/gd_iter_ctrl.sv
// Gradient-descent iteration controller: x <= x - x_diff each step (Q24.8).
// A run ends on convergence, the iteration cap, overflow/saturation or a wait timeout.
module gd_iter_ctrl #(
  parameter int          MAX_ITER     = 256,
  parameter int          ITER_W       = 16,
  parameter logic [31:0] TOL          = 32'h0000_0001,
  parameter int          WAIT_TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [31:0]       x_init,
  gd_grad_if.master         grad,
  output logic              busy,
  output logic              done,
  output logic [31:0]       x_out,
  output logic [63:0]       value_out,
  output logic [ITER_W-1:0] iter_count,
  output logic              converged,
  output logic              overflow_flag,
  output logic              timeout_flag,
  output logic [2:0]        state_dbg
);
  localparam int WAIT_W = $clog2(WAIT_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_WAIT   = 3'd2,
    S_UPDATE = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [WAIT_W-1:0]   wait_cnt_q;
  logic [31:0]         x_q, diff_q, x_out_q;
  logic [63:0]         val_q, value_out_q;
  logic                ovf_q;
  logic [ITER_W-1:0]   iter_q;
  logic                conv_q, ovf_flag_q, tmo_q;

  logic signed [32:0]  sub_res;
  logic                sat_hi, sat_lo, sat;
  logic [31:0]         x_new, abs_diff;
  logic                is_conv, cap_hit, upd_exit;
  logic                wait_accept, wait_expire;

  // 33-bit difference; the top two bits disagreeing means the Q24.8 range was left.
  assign sub_res  = $signed({x_q[31], x_q}) - $signed({diff_q[31], diff_q});
  assign sat_hi   = ~sub_res[32] & sub_res[31];
  assign sat_lo   = sub_res[32] & ~sub_res[31];
  assign sat      = sat_hi | sat_lo;
  assign x_new    = sat_hi ? 32'h7FFF_FFFF : (sat_lo ? 32'h8000_0000 : sub_res[31:0]);
  assign abs_diff = !diff_q[31] ? diff_q :
                    ((diff_q == 32'h8000_0000) ? 32'h7FFF_FFFF : (32'd0 - diff_q));
  assign is_conv  = abs_diff <= TOL;
  assign cap_hit  = (iter_q + ITER_W'(1)) == ITER_W'(MAX_ITER);
  assign upd_exit = ovf_q | sat | is_conv | cap_hit;

  // The first two WAIT cycles ignore grad_done so a level left over from the last result is not reused.
  assign wait_accept = grad.grad_done && (wait_cnt_q >= WAIT_W'(2));
  assign wait_expire = wait_cnt_q == WAIT_W'(WAIT_TIMEOUT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_LAUNCH;
      S_LAUNCH: state_d = S_WAIT;
      S_WAIT: begin
        if (wait_accept)      state_d = S_UPDATE;
        else if (wait_expire) state_d = S_DONE;
      end
      S_UPDATE: state_d = upd_exit ? S_DONE : S_LAUNCH;
      S_DONE:   state_d = start ? S_LAUNCH : S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    grad.grad_start = (state_q == S_LAUNCH);
    busy            = (state_q == S_LAUNCH) || (state_q == S_WAIT) || (state_q == S_UPDATE);
    done            = (state_q == S_DONE);
    state_dbg       = state_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt_q  <= '0;
      x_q         <= '0;
      diff_q      <= '0;
      val_q       <= '0;
      ovf_q       <= 1'b0;
      x_out_q     <= '0;
      value_out_q <= '0;
      iter_q      <= '0;
      conv_q      <= 1'b0;
      ovf_flag_q  <= 1'b0;
      tmo_q       <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            x_q        <= x_init;
            iter_q     <= '0;
            conv_q     <= 1'b0;
            ovf_flag_q <= 1'b0;
            tmo_q      <= 1'b0;
          end
        end
        S_LAUNCH: wait_cnt_q <= '0;
        S_WAIT: begin
          wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
          if (wait_accept) begin
            diff_q <= grad.grad_x_diff;
            val_q  <= grad.grad_value;
            ovf_q  <= grad.grad_overflow;
          end else if (wait_expire) begin
            tmo_q   <= 1'b1;
            x_out_q <= x_q;
          end
        end
        S_UPDATE: begin
          value_out_q <= val_q;
          iter_q      <= iter_q + ITER_W'(1);
          if (ovf_q) begin
            ovf_flag_q <= 1'b1;
            x_out_q    <= x_q;
          end else begin
            x_q <= x_new;
            if (sat)          ovf_flag_q <= 1'b1;
            else if (is_conv) conv_q     <= 1'b1;
            if (upd_exit)     x_out_q    <= x_new;
          end
        end
        default: ;
      endcase
    end
  end

  assign grad.grad_x   = x_q;
  assign x_out         = x_out_q;
  assign value_out     = value_out_q;
  assign iter_count    = iter_q;
  assign converged     = conv_q;
  assign overflow_flag = ovf_flag_q;
  assign timeout_flag  = tmo_q;
endmodule
